song_reader: RTL and testbench
==============================

Name: song_reader

Overview:
- Sequencer between the 128x16 song ROM and the note player.
- Holds a song select and a note index, fetches ROM entries, decodes them into note/duration commands and handshakes each one to the note player.
- Detects end of song; supports pause and song change.
- The ROM is instantiated outside this block: registered read, 1-cycle latency.

Parameters:
- SONG_BITS, 2, song select width (4 songs).
- IDX_BITS, 5, note index width (32 entries per song); ROM address width = SONG_BITS+IDX_BITS = 7.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- play  in  1  level; 1 = run, 0 = pause.
- song  in  SONG_BITS  selected song.
- note_done  in  1  1-cycle pulse from the note player when the current note's duration has expired.
- rom_addr  out  7  {song_q, idx}, combinational from registers.
- rom_dout  in  16  ROM word: [15] rest flag, [14:9] note, [8:3] duration, [2:0] reserved (ignored).
- note  out  6  note number for the player; 0 for a rest.
- duration  out  6  duration for the player.
- is_rest  out  1  current command is a rest.
- new_note  out  1  1-cycle pulse; note/duration/is_rest are valid and stable from this cycle until the next new_note.
- song_done  out  1  1-cycle pulse when the song finishes.

Behaviour:
- Reset values: state=IDLE, idx=0, song_q=song input; note=0, duration=0, is_rest=0, new_note=0, song_done=0.
- FSM states: IDLE, FETCH, DECODE, PLAY, DONE.
- IDLE: if play=1, go to FETCH; otherwise stay. idx is retained, so IDLE doubles as the pause state.
- FETCH: rom_addr is presented; go to DECODE.
- DECODE: rom_dout is valid this cycle.
  - If duration field = 0 (end marker): pulse song_done next cycle, go to DONE.
  - Else: register note (forced to 0 if rest flag set), duration and is_rest; go to PLAY.
- PLAY: new_note is high only in the first PLAY cycle.
  - On note_done:
    - If idx = 31: idx←0, song_done pulse, go to DONE.
    - Else idx←idx+1; go to FETCH if play=1, else IDLE (paused).
  - play=0 without note_done: stay in PLAY (the player is paused too).
- DONE: idx=0.
  - Go to IDLE when play=0, so a fresh play press restarts the song from entry 0.
  - While play stays 1, remain in DONE and issue nothing.
- Latency: play sampled 1 in IDLE at edge k → FETCH at k+1 → DECODE at k+2 → new_note high in cycle k+3.
- Next-note latency: note_done at edge k → new_note at k+3.
- Song change: in any state, if song ≠ song_q:
  - song_q←song, idx←0, state←IDLE.
  - Any pending new_note or song_done is suppressed.
  - note/duration/is_rest hold their previous values.
  - Song change has priority over note_done in the same cycle.
- note_done outside PLAY is ignored.
- reset has priority over everything.
- Reserved bits [2:0] do not affect behaviour.
- idx arithmetic wraps modulo 32; the increment never carries into the song bits.
- Outputs note, duration, is_rest and the pulse outputs are registered.

Decomposition:
- Package song_pkg:
  - ROM field positions: REST_BIT=15, NOTE_MSB/LSB=14/9, DUR_MSB/LSB=8/3.
  - Widths: NOTE_W=6, DUR_W=6.
  - FSM state encoding enum.
  - END_DURATION=0 constant.
- No sub-module is needed: single FSM plus index counter. The ROM stays a sibling instance in the top level.

Test Plan:
- Basic issue: ROM model word {0,28,48,000} at addr 0; song=0, play rises → new_note in 3rd cycle after play sampled, note=28, duration=48, is_rest=0, rom_addr=0.
- Rest decode: word {1,0,16,000} at addr 3 → note=0, duration=16, is_rest=1.
  - Also word {1,28,0,000} is treated as end marker: song_done, no new_note.
- End marker: song 0 with duration-0 word at addr 26 → after note_done of entry 25, song_done pulses once and no new_note follows; state stays DONE with play=1.
  - Drop play, raise play → rom_addr=0 and entry 0 is reissued.
- Full song / wrap: song 3 (no end marker), pulse note_done 32 times → rom_addr runs 96..127, song_done after the 32nd, rom_addr returns to 96, never 0.
- Pause: play=0 before note_done of entry 5 → state IDLE, no fetch.
  - play=1 later → new_note for entry 6 with rom_addr=6.
- Song change mid-note: song 1→2 during PLAY with note_done in the same cycle → no new_note for song 1, idx=0, rom_addr=64 on next play; reset mid-PLAY → all outputs 0 next cycle.

Source files
------------

// File: rtl/song_pkg.sv
// song_pkg
//   Shared definitions for the song sequencer: where the command fields sit
//   in a 16-bit song ROM word, the field widths, the sequencer state
//   encoding, and a decode helper that turns a ROM word into a player command.
//   No ports (package).
package song_pkg;

  // ROM word layout: [15] rest flag, [14:9] note, [8:3] duration, [2:0] reserved
  localparam int ROM_W    = 16;
  localparam int REST_BIT = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  // A zero duration marks the end of a song.
  localparam logic [DUR_W-1:0] END_DURATION = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    PLAY,
    DONE
  } state_t;

  typedef struct packed {
    logic              rest;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } cmd_t;

  // Only the meaningful bits are passed in, so the reserved bits can never
  // leak into a command. A rest always reports note 0.
  function automatic cmd_t decode_word(input logic [ROM_W-1:DUR_LSB] word);
    cmd_t cmd;
    cmd.rest = word[REST_BIT];
    cmd.note = word[REST_BIT] ? '0 : word[NOTE_MSB:NOTE_LSB];
    cmd.dur  = word[DUR_MSB:DUR_LSB];
    return cmd;
  endfunction

endpackage

// File: rtl/song_reader.sv
// song_reader
//   Sequencer between the song ROM and the note player. Holds the selected
//   song and a note index, fetches ROM entries (registered ROM, 1-cycle read
//   latency), decodes them into note/duration commands and hands each one to
//   the player with a one-cycle new_note pulse. Detects the end of a song,
//   supports pausing through the play level and restarts on a song change.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   play       in   level, 1 = run, 0 = pause
//   song       in   selected song
//   note_done  in   pulse from the player when the current note has expired
//   rom_addr   out  {song_q, idx}, straight from registers
//   rom_dout   in   ROM word for the address presented in the previous cycle
//   note       out  note number (0 for a rest)
//   duration   out  note duration
//   is_rest    out  current command is a rest
//   new_note   out  pulse, note/duration/is_rest are fresh from this cycle
//   song_done  out  pulse when the song finishes
module song_reader
  import song_pkg::*;
#(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          note_done,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [ROM_W-1:0]              rom_dout,
  output logic [NOTE_W-1:0]             note,
  output logic [DUR_W-1:0]              duration,
  output logic                          is_rest,
  output logic                          new_note,
  output logic                          song_done
);

  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

  state_t               state;
  logic [SONG_BITS-1:0] song_q;
  logic [IDX_BITS-1:0]  idx;
  cmd_t                 cmd;

  // The reserved low bits of the ROM word carry no meaning for the player.
  logic unused_reserved;
  assign unused_reserved = ^rom_dout[DUR_LSB-1:0];

  assign rom_addr = {song_q, idx};
  assign cmd      = decode_word(rom_dout[ROM_W-1:DUR_LSB]);

  // Sequencer FSM and note index. The pulse outputs default low every cycle.
  // A song change outranks everything except reset: it restarts the index,
  // parks in IDLE and leaves the last command on the outputs untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      song_q    <= song;
      note      <= '0;
      duration  <= '0;
      is_rest   <= 1'b0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      new_note  <= 1'b0;
      song_done <= 1'b0;
      if (song != song_q) begin
        song_q <= song;
        idx    <= '0;
        state  <= IDLE;
      end else begin
        case (state)
          // Also the pause state: idx is kept so play resumes where it left off.
          IDLE: begin
            if (play) state <= FETCH;
          end
          FETCH: begin
            state <= DECODE;
          end
          DECODE: begin
            if (cmd.dur == END_DURATION) begin
              song_done <= 1'b1;
              idx       <= '0;
              state     <= DONE;
            end else begin
              note     <= cmd.note;
              duration <= cmd.dur;
              is_rest  <= cmd.rest;
              new_note <= 1'b1;
              state    <= PLAY;
            end
          end
          PLAY: begin
            if (note_done) begin
              if (idx == IDX_LAST) begin
                idx       <= '0;
                song_done <= 1'b1;
                state     <= DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= play ? FETCH : IDLE;
              end
            end
          end
          // Wait for play to drop so the next press restarts from entry 0.
          DONE: begin
            idx <= '0;
            if (!play) state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader
//   Self-checking bench for song_reader. A registered ROM model holds random
//   song data with a few planted words; the expected command stream is worked
//   out from a note-level model (current song, current entry, last command).
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [15:0] rom_dout;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        is_rest;
  logic        new_note;
  logic        song_done;

  logic [15:0] rom_mem [128];

  int errors = 0;
  int checks = 0;

  // Note-level reference model state
  logic [1:0] m_song;
  logic [4:0] m_idx;
  logic [5:0] last_note;
  logic [5:0] last_dur;
  logic       last_rest;

  song_reader #(.SONG_BITS(2), .IDX_BITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .song      (song),
    .note_done (note_done),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .note      (note),
    .duration  (duration),
    .is_rest   (is_rest),
    .new_note  (new_note),
    .song_done (song_done)
  );

  always #5 clk = ~clk;

  // Registered ROM with one cycle of read latency
  always @(posedge clk) rom_dout <= rom_mem[rom_addr];

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Quiet cycles: nothing issued, address parked on the model's entry
  task automatic idleCheck(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick;
      checkOutput({tag, "/new_note"}, new_note, 0);
      checkOutput({tag, "/song_done"}, song_done, 0);
      checkOutput({tag, "/rom_addr"}, rom_addr, {m_song, m_idx});
    end
  endtask

  // Called one cycle after the trigger edge; the model's entry is either
  // issued or recognised as an end marker two cycles later.
  task automatic expectIssue(input string tag);
    logic [15:0] w;
    checkOutput({tag, "/nn_c1"}, new_note, 0);
    tick;
    checkOutput({tag, "/nn_c2"}, new_note, 0);
    checkOutput({tag, "/sd_c2"}, song_done, 0);
    tick;
    w = rom_mem[{m_song, m_idx}];
    if (w[8:3] == 6'd0) begin
      checkOutput({tag, "/end_sd"}, song_done, 1);
      checkOutput({tag, "/end_nn"}, new_note, 0);
      checkOutput({tag, "/end_note_held"}, note, last_note);
      m_idx = 5'd0;
      tick;
      checkOutput({tag, "/end_sd_once"}, song_done, 0);
      checkOutput({tag, "/end_nn_after"}, new_note, 0);
      checkOutput({tag, "/end_addr"}, rom_addr, {m_song, 5'd0});
    end else begin
      last_rest = w[15];
      last_note = w[15] ? 6'd0 : w[14:9];
      last_dur  = w[8:3];
      checkOutput({tag, "/new_note"}, new_note, 1);
      checkOutput({tag, "/note"}, note, last_note);
      checkOutput({tag, "/duration"}, duration, last_dur);
      checkOutput({tag, "/is_rest"}, is_rest, last_rest);
      checkOutput({tag, "/rom_addr"}, rom_addr, {m_song, m_idx});
      tick;
      checkOutput({tag, "/nn_pulse"}, new_note, 0);
      checkOutput({tag, "/note_stable"}, note, last_note);
    end
  endtask

  // Random wait, then a note_done pulse with the given play level
  task automatic applyStimulus(input bit pl, input string tag);
    int gap;
    gap = $urandom_range(0, 3);
    for (int g = 0; g < gap; g++) begin
      tick;
      checkOutput({tag, "/gap_nn"}, new_note, 0);
    end
    play      = pl;
    note_done = 1'b1;
    tick;
    note_done = 1'b0;
    if (m_idx == 5'd31) begin
      checkOutput({tag, "/wrap_sd"}, song_done, 1);
      checkOutput({tag, "/wrap_nn"}, new_note, 0);
      m_idx = 5'd0;
      checkOutput({tag, "/wrap_addr"}, rom_addr, {m_song, 5'd0});
      tick;
      checkOutput({tag, "/wrap_sd_once"}, song_done, 0);
      checkOutput({tag, "/wrap_nn_after"}, new_note, 0);
    end else begin
      m_idx = m_idx + 5'd1;
      if (pl) expectIssue(tag);
      else begin
        checkOutput({tag, "/pause_nn"}, new_note, 0);
        checkOutput({tag, "/pause_addr"}, rom_addr, {m_song, m_idx});
      end
    end
  endtask

  initial begin
    logic [15:0] w;
    int n;
    reset     = 1'b1;
    play      = 1'b0;
    note_done = 1'b0;
    song      = 2'd0;

    // Random song data, durations forced nonzero except for planted markers
    for (int i = 0; i < 128; i++) begin
      w = 16'($urandom);
      if (w[8:3] == 6'd0) w[8:3] = 6'd1 + 6'($urandom_range(0, 62));
      rom_mem[i] = w;
    end
    rom_mem[0]  = {1'b0, 6'd28, 6'd48, 3'b000};
    rom_mem[3]  = {1'b1, 6'd0, 6'd16, 3'b000};
    w = 16'($urandom);
    rom_mem[26] = {w[15:9], 6'd0, 3'b101};
    rom_mem[68] = {1'b1, 6'd28, 6'd0, 3'b111};

    tick;
    tick;
    checkOutput("reset/note", note, 0);
    checkOutput("reset/duration", duration, 0);
    checkOutput("reset/is_rest", is_rest, 0);
    checkOutput("reset/new_note", new_note, 0);
    checkOutput("reset/song_done", song_done, 0);
    checkOutput("reset/rom_addr", rom_addr, 0);
    reset     = 1'b0;
    m_song    = 2'd0;
    m_idx     = 5'd0;
    last_note = 6'd0;
    last_dur  = 6'd0;
    last_rest = 1'b0;
    idleCheck(2, "idle_noplay");

    // Basic issue, then song 0 through its end marker at entry 26
    play = 1'b1;
    tick;
    expectIssue("basic");
    for (int i = 1; i <= 25; i++) applyStimulus(1'b1, "song0");
    applyStimulus(1'b1, "end_marker");
    idleCheck(3, "done_hold");
    note_done = 1'b1;
    idleCheck(1, "done_nd_ignored");
    note_done = 1'b0;
    idleCheck(2, "done_hold2");

    // Release and press play again: entry 0 reissued
    play = 1'b0;
    tick;
    play = 1'b1;
    tick;
    expectIssue("restart");

    // Pause before the note_done of entry 5
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, "to_entry5");
    play = 1'b0;
    idleCheck(2, "play_held");
    applyStimulus(1'b0, "pause");
    note_done = 1'b1;
    idleCheck(1, "idle_nd_ignored");
    note_done = 1'b0;
    idleCheck(3, "paused");
    play = 1'b1;
    tick;
    expectIssue("resume");

    // Song change while idle-held in PLAY: outputs hold, index restarts
    play = 1'b0;
    song = 2'd1;
    tick;
    m_song = 2'd1;
    m_idx  = 5'd0;
    checkOutput("chg1/rom_addr", rom_addr, 7'd32);
    checkOutput("chg1/note_held", note, last_note);
    checkOutput("chg1/dur_held", duration, last_dur);
    checkOutput("chg1/rest_held", is_rest, last_rest);
    checkOutput("chg1/new_note", new_note, 0);
    play = 1'b1;
    tick;
    expectIssue("song1");
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, "song1");

    // Song change and note_done in the same cycle: song change wins
    song      = 2'd2;
    note_done = 1'b1;
    tick;
    note_done = 1'b0;
    play      = 1'b0;
    m_song    = 2'd2;
    m_idx     = 5'd0;
    checkOutput("chg2/rom_addr", rom_addr, 7'd64);
    checkOutput("chg2/new_note", new_note, 0);
    checkOutput("chg2/song_done", song_done, 0);
    checkOutput("chg2/note_held", note, last_note);
    checkOutput("chg2/dur_held", duration, last_dur);
    idleCheck(3, "chg2_idle");
    play = 1'b1;
    tick;
    expectIssue("song2");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, "song2_rest_end");

    // Song 3 has no end marker: all 32 entries then wrap back to its base
    play = 1'b0;
    tick;
    song = 2'd3;
    tick;
    m_song = 2'd3;
    m_idx  = 5'd0;
    checkOutput("chg3/rom_addr", rom_addr, 7'd96);
    play = 1'b1;
    tick;
    expectIssue("song3");
    for (int i = 1; i <= 31; i++) applyStimulus(1'b1, "song3");
    applyStimulus(1'b1, "song3_wrap");
    idleCheck(2, "wrap_done");

    // Reset in the middle of a note
    play = 1'b0;
    tick;
    play = 1'b1;
    tick;
    expectIssue("song3_again");
    reset = 1'b1;
    tick;
    checkOutput("rst_play/note", note, 0);
    checkOutput("rst_play/duration", duration, 0);
    checkOutput("rst_play/is_rest", is_rest, 0);
    checkOutput("rst_play/new_note", new_note, 0);
    checkOutput("rst_play/song_done", song_done, 0);
    checkOutput("rst_play/rom_addr", rom_addr, 7'd96);
    reset = 1'b0;
    play  = 1'b0;
    m_idx = 5'd0;
    idleCheck(2, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
